// File: rtl/alu_cntrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cntrl_pkg
//  Brief    : Opcodes, ALU-op encodings, FSM state type and control bundle
//             shared by the ALU control stage and its decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_cntrl_pkg;

    localparam logic [4:0] OPC_SUBI     = 5'b01000;
    localparam logic [4:0] OPC_ANDNI    = 5'b01010;
    localparam logic [4:0] OPC_XORI     = 5'b01011;
    localparam logic [4:0] OPC_ROLI     = 5'b10101;
    localparam logic [4:0] OPC_RORI     = 5'b10110;
    localparam logic [4:0] OPC_SRLI     = 5'b10111;
    localparam logic [4:0] OPC_RR_SHIFT = 5'b11010;
    localparam logic [4:0] OPC_RR_ARITH = 5'b11011;
    localparam logic [4:0] OPC_NOSET    = 5'b11111;

    localparam logic [2:0] ALUOP_ROT = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b100;
    localparam logic [2:0] ALUOP_AND = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

    typedef struct packed {
        logic [2:0] aluOp;
        logic       invA;
        logic       invB;
        logic       Cin;
        logic       sign;
        logic       rorSel;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/alu_cntrl_dec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cntrl_dec
//  Brief    : Pure combinational opcode/funct decoder for the ALU controls.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cntrl_dec
    import alu_cntrl_pkg::*;
#(
    parameter logic [4:0] MUL_OPC = 5'b00010
) (
    input  logic [4:0] opCode,
    input  logic [1:0] funct,
    output ctrl_t      ctrl
);

    logic w_sets;
    logic w_rrArith;
    logic w_rrShift;

    // "Sets" family: 111xx excluding the all-ones opcode
    assign w_sets    = (opCode[4:2] == 3'b111) && (opCode != OPC_NOSET);
    assign w_rrArith = (opCode == OPC_RR_ARITH);
    assign w_rrShift = (opCode == OPC_RR_SHIFT);

    always_comb begin
        ctrl = '0;
        if (opCode == MUL_OPC) begin
            ctrl.aluOp = ALUOP_ADD;
        end else begin
            ctrl.invA     = (opCode == OPC_SUBI) | (w_rrArith & (funct == 2'b01));
            ctrl.invB     = w_sets | (opCode == OPC_ANDNI) | (w_rrArith & (funct == 2'b11));
            ctrl.Cin      = w_sets | (opCode == OPC_SUBI) | (w_rrArith & (funct == 2'b01));
            ctrl.sign     = w_sets | (w_rrArith & ~funct[1]) | (opCode[4:1] == 4'b0100)
                          | (opCode[4:2] == 3'b100);
            ctrl.aluOp[2] = ~((opCode[4:2] == 3'b101) | w_rrShift);
            ctrl.aluOp[1] = (opCode == OPC_XORI) | (opCode == OPC_SRLI)
                          | (w_rrShift & (funct == 2'b11)) | (w_rrArith & (funct == 2'b10));
            ctrl.aluOp[0] = (opCode[4:1] == 4'b0101) | (opCode == OPC_ROLI) | (opCode == OPC_SRLI)
                          | (w_rrShift & funct[0]) | (w_rrArith & funct[1]);
            ctrl.rorSel   = (opCode == OPC_RORI) | (w_rrShift & (funct == 2'b10));
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cntrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cntrl_pipe
//  Brief    : Registered ALU control stage with valid/ready, stall/flush and
//             an N-step iterative multiply sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cntrl_pipe
    import alu_cntrl_pkg::*;
#(
    parameter int         N       = 16,
    parameter logic [4:0] MUL_OPC = 5'b00010,
    parameter int         CW      = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] opCode,
    input  logic [1:0] funct,
    input  logic       stall,
    input  logic       flush,
    output logic       out_valid,
    output logic [2:0] aluOp,
    output logic       invA,
    output logic       invB,
    output logic       Cin,
    output logic       sign,
    output logic       rorSel,
    output logic       mulStep,
    output logic       mulFirst,
    output logic       mulLast,
    output logic       busy
);

    localparam logic [CW-1:0] c_cntLast   = CW'(N - 1);
    localparam logic [CW-1:0] c_cntPenult = CW'(N - 2);

    ctrl_t          w_dec;
    ctrl_t          r_ctrl;
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_outValid;
    logic           w_inMul;
    logic           w_atLast;
    logic           w_accept;

    alu_cntrl_dec #(
        .MUL_OPC (MUL_OPC)
    ) u_dec (
        .opCode  (opCode),
        .funct   (funct),
        .ctrl    (w_dec)
    );

    assign w_inMul  = (r_state == ST_MUL);
    assign w_atLast = w_inMul && (r_cnt == c_cntLast);
    assign in_ready = ~rst & ~stall & ~flush & (~w_inMul | w_atLast);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_ctrl     <= '0;
        end else if (!stall) begin
            if (w_inMul && !w_atLast) begin
                r_cnt      <= r_cnt + CW'(1);
                r_outValid <= (r_cnt == c_cntPenult);
            end else if (w_accept) begin
                // Also covers the chained accept in the final multiply cycle
                r_ctrl <= w_dec;
                r_cnt  <= '0;
                if (opCode == MUL_OPC) begin
                    r_state    <= ST_MUL;
                    r_outValid <= 1'b0;
                end else begin
                    r_state    <= ST_IDLE;
                    r_outValid <= 1'b1;
                end
            end else begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign aluOp     = r_ctrl.aluOp;
    assign invA      = r_ctrl.invA;
    assign invB      = r_ctrl.invB;
    assign Cin       = r_ctrl.Cin;
    assign sign      = r_ctrl.sign;
    assign rorSel    = r_ctrl.rorSel;
    assign busy      = w_inMul;
    assign mulStep   = w_inMul & ~stall;
    assign mulFirst  = w_inMul & ~stall & (r_cnt == '0);
    assign mulLast   = w_atLast & ~stall;

endmodule
`default_nettype wire

// File: tb/tb_alu_cntrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cntrl_pipe
//  Brief    : Self-checking bench for alu_cntrl_pipe (scoreboard + timing).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cntrl_pipe;

    localparam int         N       = 16;
    localparam logic [4:0] MUL_OPC = 5'b00010;

    localparam logic [7:0] c_expSub   = 8'b100_1_0_1_1_0;
    localparam logic [7:0] c_expAndni = 8'b101_0_1_0_0_0;
    localparam logic [7:0] c_expRor   = 8'b000_0_0_0_0_1;
    localparam logic [7:0] c_expAdd   = 8'b100_0_0_0_1_0;
    localparam logic [7:0] c_expMul   = 8'b100_0_0_0_0_0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] opCode = '0;
    logic [1:0] funct = '0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [2:0] aluOp;
    logic       invA, invB, Cin, sign, rorSel;
    logic       mulStep, mulFirst, mulLast, busy;

    int         nVec = 0;
    int         nErr = 0;
    logic [7:0] sb[$];
    bit         r_holdEdge = 1'b0;

    alu_cntrl_pipe #(
        .N       (N),
        .MUL_OPC (MUL_OPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opCode    (opCode),
        .funct     (funct),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .aluOp     (aluOp),
        .invA      (invA),
        .invB      (invB),
        .Cin       (Cin),
        .sign      (sign),
        .rorSel    (rorSel),
        .mulStep   (mulStep),
        .mulFirst  (mulFirst),
        .mulLast   (mulLast),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the opcode table
    function automatic logic [7:0] refDec(input logic [4:0] op, input logic [1:0] f);
        logic sets, ra, rs;
        logic [2:0] a;
        logic ia, ib, ci, sg, rr;
        if (op == MUL_OPC) return c_expMul;
        sets = (op[4:2] == 3'b111) && (op != 5'b11111);
        ra   = (op == 5'b11011);
        rs   = (op == 5'b11010);
        ia   = (op == 5'b01000) || (ra && f == 2'b01);
        ib   = sets || (op == 5'b01010) || (ra && f == 2'b11);
        ci   = sets || (op == 5'b01000) || (ra && f == 2'b01);
        sg   = sets || (ra && f[1] == 1'b0) || (op == 5'b01000) || (op == 5'b01001)
            || (op[4:2] == 3'b100);
        a[2] = !((op[4:2] == 3'b101) || rs);
        a[1] = (op == 5'b01011) || (op == 5'b10111) || (rs && f == 2'b11) || (ra && f == 2'b10);
        a[0] = (op == 5'b01010) || (op == 5'b01011) || (op == 5'b10101) || (op == 5'b10111)
            || (rs && f[0]) || (ra && f[1]);
        rr   = (op == 5'b10110) || (rs && f == 2'b10);
        return {a, ia, ib, ci, sg, rr};
    endfunction

    always @(posedge clk) r_holdEdge <= stall & ~flush & ~rst;

    // One pop per newly produced bundle; a stall-held bundle is not re-popped
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !r_holdEdge) begin
            chk("sbDepth", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
                chk("bundle", {24'd0, aluOp, invA, invB, Cin, sign, rorSel}, {24'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runMul(input int stallAt, input int stallLen, input bit chain);
        int total;
        bit st, last;
        total = N + stallLen;
        sb.push_back(c_expMul);
        in_valid = 1'b1; opCode = MUL_OPC; funct = 2'b00;
        #1 chk("mulAcceptReady", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= total; k++) begin
            st   = (stallLen > 0) && (k >= stallAt) && (k < stallAt + stallLen);
            last = (k == total);
            stall = st;
            if (chain && last) begin
                in_valid = 1'b1; opCode = 5'b11011; funct = 2'b00;
                sb.push_back(c_expAdd);
            end
            #1;
            chk("mulStep", mulStep, !st);
            chk("mulFirst", mulFirst, (k == 1));
            chk("mulLast", mulLast, last);
            chk("busy", busy, 1);
            chk("inReadyMul", in_ready, last);
            chk("outValidMul", out_valid, last);
            tick();
        end
        stall = 1'b0;
        in_valid = 1'b0;
        chk("postMulValid", out_valid, chain);
        chk("postMulBusy", busy, 0);
        if (chain) begin
            chk("chainAluOp", aluOp, 3'b100);
            chk("chainSign", sign, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset with a multiply presented: nothing may be accepted
        in_valid = 1'b1; opCode = MUL_OPC;
        tick(); tick();
        chk("rstInReady", in_ready, 0);
        chk("rstOutValid", out_valid, 0);
        chk("rstCtrl", {aluOp, invA, invB, Cin, sign, rorSel}, 0);
        chk("rstStrobes", {mulStep, mulFirst, mulLast, busy}, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("postRstReady", in_ready, 1);
        tick();

        // Back-to-back single-cycle decodes
        in_valid = 1'b1; opCode = 5'b11011; funct = 2'b01; sb.push_back(c_expSub);
        tick(); chk("b2bValid0", out_valid, 1);
        opCode = 5'b01010; funct = 2'b00; sb.push_back(c_expAndni);
        tick(); chk("b2bValid1", out_valid, 1);
        opCode = 5'b11010; funct = 2'b10; sb.push_back(c_expRor);
        tick(); chk("b2bValid2", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("bubbleValid", out_valid, 0);
        chk("bubbleHold", {aluOp, invA, invB, Cin, sign, rorSel}, c_expRor);

        // Stall holds a single-cycle bundle and blocks acceptance
        in_valid = 1'b1; opCode = 5'b11011; funct = 2'b01; sb.push_back(c_expSub);
        tick();
        opCode = 5'b01010; funct = 2'b00; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("stallReady", in_ready, 0);
            tick();
            chk("stallHoldValid", out_valid, 1);
            chk("stallHoldCtrl", {aluOp, invA, invB, Cin, sign, rorSel}, c_expSub);
        end
        stall = 1'b0; sb.push_back(c_expAndni);
        tick();
        in_valid = 1'b0;
        tick();

        // Plain multiply, stalled multiply, chained multiply then ADD
        runMul(0, 0, 1'b0);
        tick();
        runMul(8, 3, 1'b0);
        tick();
        runMul(0, 0, 1'b1);
        tick();

        // Flush mid-multiply with a new instruction offered
        in_valid = 1'b1; opCode = MUL_OPC; funct = 2'b00;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        flush = 1'b1; in_valid = 1'b1; opCode = 5'b11011; funct = 2'b00;
        #1 chk("flushReady", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flushBusy", busy, 0);
        chk("flushValid", out_valid, 0);
        chk("flushCtrl", {aluOp, invA, invB, Cin, sign, rorSel}, 0);
        chk("flushStep", mulStep, 0);
        tick();
        chk("flushDropped", out_valid, 0);

        // Reset at multiply step 5
        in_valid = 1'b1; opCode = MUL_OPC;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midRstValid", out_valid, 0);
        chk("midRstCtrl", {aluOp, invA, invB, Cin, sign, rorSel}, 0);
        chk("midRstBusy", busy, 0);
        chk("midRstStrobes", {mulStep, mulFirst, mulLast}, 0);
        chk("midRstReady", in_ready, 0);
        rst = 1'b0;
        #1 chk("midRstReadyAfter", in_ready, 1);
        tick();

        // Random non-multiply decodes with occasional bubbles
        for (int i = 0; i < 48; i++) begin
            logic [4:0] op;
            logic [1:0] f;
            op = 5'($urandom_range(0, 31));
            f  = 2'($urandom_range(0, 3));
            if (op == MUL_OPC) op = op ^ 5'b00001;
            in_valid = ($urandom_range(0, 3) != 0);
            opCode = op; funct = f;
            if (in_valid) sb.push_back(refDec(op, f));
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        chk("sbDrain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cntrl_pipe.md
# alu_cntrl_pipe

Registered, parametrised ALU control stage for the execute pipeline. It decodes `opCode`/`funct` into the ALU control bundle, registers it into the EX stage behind a valid/ready handshake, and honours pipeline `stall` and `flush`. It also sequences a new multi-cycle iterative multiply (`MUL_OPC`) that occupies the ALU for `N` cycles.

## Interface
- `N`, 16: datapath width; also the multiply step count.
- `MUL_OPC`, 5'b00010: opcode that selects the iterative multiply.
- `CW`, `$clog2(N)`: step-counter width (derived; do not override).

- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: decode stage presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `opCode` in 5, `funct` in 2: instruction fields.
- `stall` in 1: downstream hold.
- `flush` in 1: kill the in-flight instruction.
- `out_valid` out 1: registered bundle valid.
- `aluOp` out 3, `invA` out 1, `invB` out 1, `Cin` out 1, `sign` out 1, `rorSel` out 1: registered ALU controls.
- `mulStep` out 1, `mulFirst` out 1, `mulLast` out 1: multiply sequencing strobes.
- `busy` out 1: multiply in progress.

## Operation
- **Decode (combinational, before the register).** "Sets" means `111xx` except `11111`.
  - `invA` = SUBI `01000` | (`11011` & f=01).
  - `invB` = sets | ANDNI `01010` | (`11011` & f=11).
  - `Cin` = sets | `01000` | (`11011` & f=01).
  - `sign` = sets | (`11011` & f=0x) | `0100x` | `100xx`.
  - `aluOp[2]` = 0 for `101xx` and `11010`, else 1.
  - `aluOp[1]` = `01011` | `10111` | (`11010` & f=11) | (`11011` & f=10).
  - `aluOp[0]` = `0101x` | `10101` | `10111` | (`11010` & f[0]) | (`11011` & f[1]).
  - `rorSel` = `10110` | (`11010` & f=10).
  - The `MUL_OPC` bundle is forced to `aluOp`=100 with all other controls 0.
- **FSM: IDLE and MUL.**
  - IDLE, accept of non-MUL: register the bundle; `out_valid`=1 next cycle.
  - IDLE, accept of MUL: go to MUL with `cnt`=0 and register the bundle.
  - MUL: `mulStep`=1 each non-stalled cycle.
    - `mulFirst` is asserted when `cnt`=0; `mulLast` when `cnt`=N-1.
    - `cnt` increments by 1 per non-stalled cycle. It never wraps: at N-1 the FSM returns to IDLE.
    - `out_valid`=1 only in the `mulLast` cycle.
    - `busy`=1 throughout MUL.
- **Handshake.**
  - `in_ready` = ~`rst` & ~`stall` & ~`flush` & (IDLE | `cnt`==N-1).
  - An accept in the `mulLast` cycle chains back-to-back with no bubble.
- **No accept.** If there is no accept and no stall, `out_valid` drops to 0 next cycle (bubble) and control outputs hold their last value.
- **Stall.** Output registers, `cnt` and the state hold. `out_valid` holds. Strobes are gated to 0.
- **Flush.** Flush has priority over stall and `in_valid`. Next cycle: IDLE, `cnt`=0, `out_valid`=0, all controls and strobes 0. A simultaneous `in_valid` is dropped.
- **Reset.** Takes priority over everything, including mid-multiply.

## Timing
- Reset values: `out_valid`, `aluOp`, `invA`, `invB`, `Cin`, `sign`, `rorSel`, `mulStep`, `mulFirst`, `mulLast`, `busy` all 0. `in_ready`=0 during `rst` and 1 the cycle after.
- Single-cycle op: accept at edge t, bundle and `out_valid` visible after edge t. Throughput is 1/cycle with no stall.
- MUL accepted at edge t:
  - `mulFirst` in cycle t+1.
  - `mulLast` and `out_valid` in cycle t+N.
  - Each stalled cycle adds 1.
- All outputs are registered except `in_ready` and the gated strobes.

## Structure
- Package `alu_cntrl_pkg` holds:
  - opcode constants (`OPC_SUBI`, `OPC_ANDNI`, `OPC_RR_ARITH`=`11011`, `OPC_RR_SHIFT`=`11010`, etc.);
  - `aluOp` encodings;
  - FSM state type;
  - the control-bundle struct.
- One sub-module, `alu_cntrl_dec`: the pure combinational decoder. This block instantiates it and adds the register, FSM and counter.

## Test plan
- **Reset mid-MUL:** `rst` at step 5 → next cycle all outputs 0, `busy`=0, `in_ready`=1 one cycle after `rst` deasserts.
- **Back-to-back single-cycle decodes:** SUB (`11011`, f=01), then ANDNI (`01010`), then ROR (`11010`, f=10) →
  - SUB: `aluOp`=100, `invA`=1, `invB`=0, `Cin`=1, `sign`=1, `rorSel`=0;
  - ANDNI: `aluOp`=101, `invA`=0, `invB`=1, `Cin`=0, `sign`=0, `rorSel`=0;
  - ROR: `aluOp`=000, all other controls 0 except `rorSel`=1;
  - `out_valid` high for 3 consecutive cycles.
- **MUL, N=16, accept at t:** `mulFirst` at t+1, `mulLast` and `out_valid` at t+16, `in_ready`=0 for t+1..t+15.
- **Stall during MUL:** `stall` for 3 cycles at `cnt`=7 → `cnt` holds at 7, `mulLast` moves to t+19, `in_ready`=0 while stalled.
- **Flush with `in_valid` high during MUL:** → instruction dropped; next cycle IDLE, `out_valid`=0, `busy`=0.
- **Chained MUL then ADD:** ADD (`11011`, f=00) accepted in the `mulLast` cycle → ADD bundle (`aluOp`=100, `sign`=1) valid the next cycle with no bubble.
